// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//
// Multi-mode barrel shifter built from O log steps. The steps are spread
// over S register stages, so a shift can close timing at clock rates that
// a single-cycle log-shifter cannot reach. Operands and results move through
// valid/ready handshakes with full backpressure. Results leave in the order
// the operands arrived.
//
// Parameters
//   N  operand/result width (N >= 2)
//   O  shift-amount width, $clog2(N)
//   S  register stages (1 <= S <= O)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand present on a, b, m
//   in_ready   operand accepted this cycle
//   a          operand
//   b          shift amount
//   m          mode: 00 logical right, 01 arithmetic right,
//              10 rotate right, 11 logical left
//   out_valid  result present on c
//   out_ready  consumer takes the result this cycle
//   c          result
module pipelined_barrel_shifter #(
  parameter int N = 8,
  parameter int O = $clog2(N),
  parameter int S = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [O-1:0] b,
  input  logic [1:0]   m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c
);

  localparam int STEPS_PER_STAGE = (O + S - 1) / S;

  // One log step: shift or rotate x right (left for mode 11) by sh bits.
  // sh is always a power of two below N, so the rotate needs one wrap only.
  function automatic logic [N-1:0] shift_step(input logic [N-1:0] x,
                                              input int          sh,
                                              input logic [1:0]  md,
                                              input logic        sgn);
    logic [2*N-1:0] w;
    case (md)
      2'b00:   w = {{N{1'b0}}, x} >> sh;
      2'b01:   w = {{N{sgn}}, x} >> sh;
      2'b10:   w = {x, x} >> sh;
      default: w = {x, x} << sh;
    endcase
    return w[N-1:0];
  endfunction

  // Amounts of N or more only exist when N is not a power of two. They are
  // folded into an in-range equivalent before the first stage: rotates wrap
  // once (b < 2N always), the other modes collapse to their fill pattern
  // with a zero residual shift.
  logic [N-1:0] a_rng;
  logic [O-1:0] b_rng;

  always_comb begin
    a_rng = a;
    b_rng = b;
    if (int'(b) >= N) begin
      if (m == 2'b10) begin
        b_rng = O'(int'(b) - N);
      end else begin
        b_rng = '0;
        a_rng = (m == 2'b01) ? {N{a[N-1]}} : '0;
      end
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int LO = k * STEPS_PER_STAGE;
    localparam int HI = ((k + 1) * STEPS_PER_STAGE < O) ? (k + 1) * STEPS_PER_STAGE : O;

    logic [N-1:0] data_p;
    logic [O-1:0] amt_p;
    logic [1:0]   mode_p;
    logic         sign_p;
    logic         vld_p;

    logic [N-1:0] src_d;
    logic [N-1:0] nxt_d;
    logic [O-1:0] src_b;
    logic [1:0]   src_m;
    logic         src_s;
    logic         src_v;
    logic         take;
    logic         adv;

    if (k == 0) begin : g_src_in
      assign src_v = in_valid;
      assign src_d = a_rng;
      assign src_b = b_rng;
      assign src_m = m;
      assign src_s = a[N-1];
    end else begin : g_src_up
      assign src_v = g_stage[k-1].vld_p;
      assign src_d = g_stage[k-1].data_p;
      assign src_b = g_stage[k-1].amt_p;
      assign src_m = g_stage[k-1].mode_p;
      assign src_s = g_stage[k-1].sign_p;
    end

    if (k == S - 1) begin : g_take_out
      assign take = out_ready;
    end else begin : g_take_up
      assign take = g_stage[k+1].adv;
    end

    // A stage refills whenever it is empty or its content moves on.
    assign adv = !vld_p || take;

    // Steps LO..HI-1 belong to this stage; stages past the last step pass through.
    always_comb begin
      nxt_d = src_d;
      for (int j = 0; j < O; j++) begin
        if (j >= LO && j < HI && src_b[j]) begin
          nxt_d = shift_step(nxt_d, 1 << j, src_m, src_s);
        end
      end
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p <= 1'b0;
      end else if (adv) begin
        vld_p <= src_v;
      end
    end

    always_ff @(posedge clk) begin
      if (adv && src_v) begin
        amt_p  <= src_b;
        mode_p <= src_m;
        sign_p <= src_s;
      end
    end

    if (k == S - 1) begin : g_out
      // The final data register drives c, which must read zero after reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_p <= '0;
        end else if (adv && src_v) begin
          data_p <= nxt_d;
        end
      end
      // The final stage's control fields have no downstream consumer.
      logic unused_ctl;
      assign unused_ctl = ^{amt_p, mode_p, sign_p};
    end else begin : g_pipe
      always_ff @(posedge clk) begin
        if (adv && src_v) begin
          data_p <= nxt_d;
        end
      end
    end
  end

  // Outputs are forced to their reset values for the whole rst cycle, so an
  // in-flight result is never presented while it is being discarded.
  assign in_ready  = !rst && g_stage[0].adv;
  assign out_valid = !rst && g_stage[S-1].vld_p;
  assign c         = rst ? '0 : g_stage[S-1].data_p;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Testbench for pipelined_barrel_shifter: a directed N=8/S=3 instance
// (fill, backpressure, mid-operation reset) plus randomized scoreboard
// instances for N=8/S=1 (full sweep), N=16/S=1..4 (shared stream) and
// N=6/S=2 (out-of-range amounts).
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] stream [1000];
  bit          stream_ready = 1'b0;
  logic        rst_r = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference shifter on plain integers.
  function automatic logic [31:0] ref_shift(input int n, input logic [31:0] x_in,
                                            input int amt, input int md);
    logic [31:0] mask, x, r;
    logic        sgn;
    int          rot;
    mask = (32'd1 << n) - 32'd1;
    x    = x_in & mask;
    sgn  = x[n-1];
    case (md)
      0: r = (amt >= n) ? 32'd0 : (x >> amt);
      1: r = (amt >= n) ? (sgn ? mask : 32'd0)
                        : ((x >> amt) | (sgn ? (mask & ~(mask >> amt)) : 32'd0));
      2: begin
        rot = amt % n;
        r   = ((x >> rot) | (x << (n - rot))) & mask;
      end
      default: r = (amt >= n) ? 32'd0 : ((x << amt) & mask);
    endcase
    return r;
  endfunction

  function automatic int cfg_n(input int g);
    case (g)
      0:       return 8;
      5:       return 6;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_s(input int g);
    case (g)
      0, 1:    return 1;
      2:       return 2;
      3:       return 3;
      4:       return 4;
      default: return 2;
    endcase
  endfunction

  // N=6 directed vectors with a = 6'b100110.
  function automatic int n6_b(input int k);
    return (k < 3) ? 7 : 0;
  endfunction
  function automatic int n6_m(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      2:       return 2;
      default: return 1;
    endcase
  endfunction
  function automatic logic [31:0] n6_exp(input int k);
    case (k)
      0:       return 32'h3F;
      1:       return 32'h00;
      2:       return 32'h13;
      default: return 32'h26;
    endcase
  endfunction

  // ------------------------------------------------------------------
  // Randomized scoreboard instances
  // ------------------------------------------------------------------
  localparam int NCFG = 6;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int  N        = cfg_n(g);
    localparam int  S        = cfg_s(g);
    localparam int  O        = $clog2(N);
    localparam int  NOPS     = (g == 0) ? 8192 : 1000;
    localparam bit  RAND_RDY = (g == 0 || g == 5);

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0] a, c;
    logic [O-1:0] b;
    logic [1:0]   m;
    logic [31:0]  exp_q [$];
    int           acc_q [$];
    int           n_out = 0;
    bit           done  = 1'b0;

    pipelined_barrel_shifter #(.N(N), .O(O), .S(S)) dut (
      .clk(clk), .rst(rst_r),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .m(m),
      .out_valid(out_valid), .out_ready(out_ready), .c(c)
    );

    initial begin : drv
      int          i;
      logic [31:0] ev;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a = '0; b = '0; m = '0;
      i = 0;
      wait (stream_ready && !rst_r);
      while (i < NOPS) begin
        @(posedge clk); #1;
        out_ready = RAND_RDY ? ($urandom_range(3) != 0) : 1'b1;
        in_valid  = ($urandom_range(3) != 0);
        if (g == 0) begin
          a = N'(i);
          b = O'(i >> 8);
          m = 2'(i >> 11);
          ev = ref_shift(N, 32'(a), int'(b), int'(m));
        end else if (g == 5 && i < 4) begin
          a  = N'(6'b100110);
          b  = O'(n6_b(i));
          m  = 2'(n6_m(i));
          ev = n6_exp(i);
        end else begin
          a = N'(stream[i]);
          b = O'(stream[i] >> 16);
          m = 2'(stream[i] >> 24);
          ev = ref_shift(N, 32'(a), int'(b), int'(m));
        end
        @(negedge clk);
        if (in_valid && in_ready) begin
          exp_q.push_back(ev);
          acc_q.push_back(cyc);
          i++;
        end
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
      check($sformatf("cfg%0d_drained", g), 32'(exp_q.size()), 32'd0);
      check($sformatf("cfg%0d_count", g), 32'(n_out), 32'(NOPS));
      done = 1'b1;
    end

    always @(negedge clk) begin : mon
      logic [31:0] e;
      int          t;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("cfg%0d_unexpected_out", g), 32'(c), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          n_out++;
          check($sformatf("cfg%0d_c", g), 32'(c), e);
          if (!RAND_RDY) check($sformatf("cfg%0d_latency", g), 32'(cyc - t), 32'(S));
          else           check($sformatf("cfg%0d_latency_min", g), 32'(cyc - t >= S), 32'd1);
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Directed instance, N=8 S=3
  // ------------------------------------------------------------------
  logic       rst_d = 1'b1;
  logic       d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b0;
  logic [7:0] d_a = '0, d_c;
  logic [2:0] d_b = '0;
  logic [1:0] d_m = '0;
  logic [7:0] d_exp = '0;
  logic [7:0] c_hold = '0;
  bit         d_lat = 1'b0;
  int         d_acc = 0;
  logic [31:0] exp_d [$];
  int          acc_d [$];
  logic [7:0]  fill_exp [4] = '{8'h2D, 8'hED, 8'h2D, 8'hD0};

  pipelined_barrel_shifter #(.N(8), .O(3), .S(3)) dut_d (
    .clk(clk), .rst(rst_d),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .m(d_m),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .c(d_c)
  );

  always @(negedge clk) begin : mon_d
    logic [31:0] e;
    int          t;
    if (d_out_valid && d_out_ready) begin
      if (exp_d.size() == 0) begin
        check("d_unexpected_out", 32'(d_c), 32'hFFFF_FFFF);
      end else begin
        e = exp_d.pop_front();
        t = acc_d.pop_front();
        check("d_c", 32'(d_c), e);
        if (d_lat) check("d_latency", 32'(cyc - t), 32'd3);
      end
    end
  end

  // Starts and ends 1 time unit after a rising edge.
  task automatic d_tick();
    @(negedge clk);
    if (d_in_valid && d_in_ready) begin
      exp_d.push_back(32'(d_exp));
      acc_d.push_back(cyc);
      d_acc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic d_rand_op();
    d_a   = 8'($urandom);
    d_b   = 3'($urandom);
    d_m   = 2'($urandom);
    d_exp = 8'(ref_shift(8, 32'(d_a), int'(d_b), int'(d_m)));
  endtask

  task automatic d_drain(input string name);
    d_in_valid = 1'b0;
    for (int k = 0; k < 30 && exp_d.size() != 0; k++) d_tick();
    check(name, 32'(exp_d.size()), 32'd0);
  endtask

  initial begin
    bit all_done;
    for (int i = 0; i < 1000; i++) stream[i] = $urandom;
    stream_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(d_in_ready), 32'd0);
    check("rst_out_valid", 32'(d_out_valid), 32'd0);
    check("rst_c", 32'(d_c), 32'd0);
    @(posedge clk); #1;
    rst_d = 1'b0;
    rst_r = 1'b0;
    @(negedge clk);
    check("first_in_ready", 32'(d_in_ready), 32'd1);
    check("first_out_valid", 32'(d_out_valid), 32'd0);
    check("first_c", 32'(d_c), 32'd0);
    @(posedge clk); #1;

    // Fill: a=B4, b=2, all four modes back to back
    d_out_ready = 1'b1;
    d_lat       = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_in_valid = 1'b1;
      d_a   = 8'hB4;
      d_b   = 3'd2;
      d_m   = 2'(k);
      d_exp = fill_exp[k];
      d_tick();
    end
    d_drain("fill_drain");

    // Backpressure: out_ready low, in_valid high for 6 cycles
    d_lat       = 1'b0;
    d_out_ready = 1'b0;
    d_acc       = 0;
    for (int k = 0; k < 6; k++) begin
      d_in_valid = 1'b1;
      d_rand_op();
      @(negedge clk);
      if (k >= 3) begin
        check("bp_in_ready_low", 32'(d_in_ready), 32'd0);
        check("bp_out_valid", 32'(d_out_valid), 32'd1);
        if (k == 3) c_hold = d_c;
        else        check("bp_c_stable", 32'(d_c), 32'(c_hold));
      end
      if (d_in_valid && d_in_ready) begin
        exp_d.push_back(32'(d_exp));
        acc_d.push_back(cyc);
        d_acc++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepts", 32'(d_acc), 32'd3);
    d_out_ready = 1'b1;
    d_rand_op();
    @(negedge clk);
    check("bp_release_in_ready", 32'(d_in_ready), 32'd1);
    if (d_in_valid && d_in_ready) begin
      exp_d.push_back(32'(d_exp));
      acc_d.push_back(cyc);
    end
    @(posedge clk); #1;
    d_drain("bp_drain");

    // Mid-operation reset
    d_lat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d_in_valid = 1'b1;
      d_rand_op();
      d_tick();
    end
    rst_d      = 1'b1;
    d_in_valid = 1'b0;
    exp_d.delete();
    acc_d.delete();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(d_out_valid), 32'd0);
    check("mid_rst_c", 32'(d_c), 32'd0);
    check("mid_rst_in_ready", 32'(d_in_ready), 32'd0);
    @(posedge clk); #1;
    rst_d = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) check("mid_post_in_ready", 32'(d_in_ready), 32'd1);
      check("mid_post_out_valid", 32'(d_out_valid), 32'd0);
      check("mid_post_c", 32'(d_c), 32'd0);
      @(posedge clk); #1;
    end

    // Wait for the randomized instances
    all_done = 1'b0;
    for (int k = 0; k < 60000 && !all_done; k++) begin
      @(posedge clk);
      all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done &&
                 g_cfg[3].done && g_cfg[4].done && g_cfg[5].done;
    end
    check("random_runs_complete", 32'(all_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
